// File: rtl/cpu_pipe_ctrl.sv
// Pipeline sequencing controller for the 8-bit five-stage CPU (F/D/E/M/W).
// Owns the D/E/M/W valid bits, derives fetch/decode stall, squash and PC
// redirect from load-use hazards, taken branches, memory wait and HLT, and
// keeps a saturating count of hazard-stall cycles.
module cpu_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             FETCH_VALID_I,
  input  logic [2:0]       D_SRC_A_I,
  input  logic             D_SRC_A_CS_I,
  input  logic [2:0]       D_SRC_B_I,
  input  logic             D_SRC_B_CS_I,
  input  logic             D_HLT_I,
  input  logic [2:0]       E_DSTR_I,
  input  logic             E_DSTR_CS_I,
  input  logic             E_DSTR_CS_E_I,
  input  logic             E_DSTR_CS_M_I,
  input  logic [2:0]       M_DSTR_I,
  input  logic             M_DSTR_CS_I,
  input  logic             M_DSTR_CS_M_I,
  input  logic             BR_TAKEN_I,
  input  logic             MEM_WAIT_I,
  input  logic             INT_I,
  input  logic             CNT_CLR_I,
  output logic             D_VALID_O,
  output logic             E_VALID_O,
  output logic             M_VALID_O,
  output logic             W_VALID_O,
  output logic             F_STALL_O,
  output logic             D_STALL_O,
  output logic             PC_SEL_O,
  output logic             HALTED_O,
  output logic             INT_ACK_O,
  output logic [CNT_W-1:0] STALL_CNT_O
);

  typedef enum logic {RUN, HALT} state_t;

  state_t state, state_nxt;

  logic d_v, e_v, m_v, w_v;
  logic int_ack;
  logic [CNT_W-1:0] stall_cnt;

  logic freeze, redir, haz, haz_a, haz_b, hlt_go, halt_exit;
  logic e_hit_a, e_hit_b, m_hit_a, m_hit_b, e_prod, m_prod;

  // A producer in E blocks D whether its result is from the ALU or memory;
  // a producer in M blocks D only when its result comes from memory.
  assign e_prod  = e_v & E_DSTR_CS_I & (E_DSTR_CS_E_I | E_DSTR_CS_M_I);
  assign m_prod  = m_v & M_DSTR_CS_I & M_DSTR_CS_M_I;
  assign e_hit_a = e_prod & (E_DSTR_I == D_SRC_A_I);
  assign e_hit_b = e_prod & (E_DSTR_I == D_SRC_B_I);
  assign m_hit_a = m_prod & (M_DSTR_I == D_SRC_A_I);
  assign m_hit_b = m_prod & (M_DSTR_I == D_SRC_B_I);
  assign haz_a   = d_v & D_SRC_A_CS_I & (e_hit_a | m_hit_a);
  assign haz_b   = d_v & D_SRC_B_CS_I & (e_hit_b | m_hit_b);
  assign haz     = haz_a | haz_b;

  assign freeze    = MEM_WAIT_I;
  assign redir     = e_v & BR_TAKEN_I & ~freeze;
  assign hlt_go    = (state == RUN) & d_v & D_HLT_I & ~haz & ~redir & ~freeze;
  assign halt_exit = (state == HALT) & INT_I & ~freeze;

  // State register and the registered interrupt-acknowledge pulse
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= RUN;
      int_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      int_ack <= halt_exit;
    end
  end

  // Next-state: enter HALT when HLT leaves D, leave it on an interrupt
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (hlt_go)    state_nxt = HALT;
      HALT: if (halt_exit) state_nxt = RUN;
      default:             state_nxt = RUN;
    endcase
  end

  // Stall/redirect outputs: freeze > redirect > halt > hazard > HLT issue
  always_comb begin
    F_STALL_O = 1'b0;
    D_STALL_O = 1'b0;
    PC_SEL_O  = 1'b0;
    if (freeze) begin
      F_STALL_O = 1'b1;
      D_STALL_O = 1'b1;
    end else if (redir) begin
      PC_SEL_O  = 1'b1;
    end else if (state == HALT || haz) begin
      F_STALL_O = 1'b1;
      D_STALL_O = 1'b1;
    end else if (hlt_go) begin
      // hold the PC so the instruction after HLT is refetched on wake-up
      F_STALL_O = 1'b1;
    end
  end

  // Stage valid bits: older stages always shift unless the pipe is frozen
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      d_v <= 1'b0;
      e_v <= 1'b0;
      m_v <= 1'b0;
      w_v <= 1'b0;
    end else if (!freeze) begin
      w_v <= m_v;
      m_v <= e_v;
      if (redir || state == HALT) begin
        e_v <= 1'b0;
        d_v <= 1'b0;
      end else if (haz) begin
        e_v <= 1'b0;
      end else if (hlt_go) begin
        e_v <= d_v;
        d_v <= 1'b0;
      end else begin
        e_v <= d_v;
        d_v <= FETCH_VALID_I;
      end
    end
  end

  // Saturating hazard-stall counter; clear beats a same-cycle increment
  always_ff @(posedge CLK_I) begin
    if (RST_I || CNT_CLR_I) begin
      stall_cnt <= '0;
    end else if (haz && !redir && !freeze && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign D_VALID_O   = d_v;
  assign E_VALID_O   = e_v;
  assign M_VALID_O   = m_v;
  assign W_VALID_O   = w_v;
  assign HALTED_O    = (state == HALT);
  assign INT_ACK_O   = int_ack;
  assign STALL_CNT_O = stall_cnt;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Self-checking bench for cpu_pipe_ctrl: directed vector table, hand-written
// HALT/saturation/reset sequences, then random stimulus against a model.
module tb_cpu_pipe_ctrl;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, fetch, ca, cb, hlt, ec, ece, ecm, mc, mcm, br, mw, intr, clr;
  logic [2:0] sa, sb, ed, md;
  logic dv, ev, mvld, wv, fs, ds, pcs, halted, ack;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_pipe_ctrl #(.CNT_W(CW)) dut (
    .CLK_I(clk), .RST_I(rst), .FETCH_VALID_I(fetch),
    .D_SRC_A_I(sa), .D_SRC_A_CS_I(ca), .D_SRC_B_I(sb), .D_SRC_B_CS_I(cb),
    .D_HLT_I(hlt), .E_DSTR_I(ed), .E_DSTR_CS_I(ec), .E_DSTR_CS_E_I(ece),
    .E_DSTR_CS_M_I(ecm), .M_DSTR_I(md), .M_DSTR_CS_I(mc), .M_DSTR_CS_M_I(mcm),
    .BR_TAKEN_I(br), .MEM_WAIT_I(mw), .INT_I(intr), .CNT_CLR_I(clr),
    .D_VALID_O(dv), .E_VALID_O(ev), .M_VALID_O(mvld), .W_VALID_O(wv),
    .F_STALL_O(fs), .D_STALL_O(ds), .PC_SEL_O(pcs), .HALTED_O(halted),
    .INT_ACK_O(ack), .STALL_CNT_O(cnt)
  );

  typedef struct {
    bit rst, fetch;
    bit [2:0] sa; bit ca;
    bit [2:0] sb; bit cb;
    bit hlt;
    bit [2:0] ed; bit ec, ece, ecm;
    bit [2:0] md; bit mc, mcm;
    bit br, mw, intr, clr;
  } in_t;

  typedef struct {
    in_t in;
    bit [3:0] v;   // {D,E,M,W}
    bit st;
    bit pc;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: pipeline occupancy as an array indexed D=0,E=1,M=2,W=3
  int mvalid[4];
  bit mhalt, mack;
  int mcnt;

  function automatic in_t idle();
    in_t x;
    x = '{default: 0};
    return x;
  endfunction

  function automatic bit m_haz(in_t x);
    bit h;
    h = 0;
    for (int s = 0; s < 2; s++) begin
      bit [2:0] src;
      bit cs;
      src = (s == 0) ? x.sa : x.sb;
      cs  = (s == 0) ? x.ca : x.cb;
      if (mvalid[0] == 1 && cs &&
          ((mvalid[1] == 1 && x.ec && x.ed == src && (x.ece || x.ecm)) ||
           (mvalid[2] == 1 && x.mc && x.md == src && x.mcm)))
        h = 1;
    end
    return h;
  endfunction

  function automatic bit m_redir(in_t x);
    return !x.mw && mvalid[1] == 1 && x.br;
  endfunction

  function automatic bit m_go(in_t x);
    return !mhalt && !x.mw && !m_redir(x) && !m_haz(x) && mvalid[0] == 1 && x.hlt;
  endfunction

  function automatic bit m_fs(in_t x);
    if (x.mw) return 1;
    if (m_redir(x)) return 0;
    return mhalt || m_haz(x) || m_go(x);
  endfunction

  function automatic bit m_ds(in_t x);
    if (x.mw) return 1;
    if (m_redir(x)) return 0;
    return mhalt || m_haz(x);
  endfunction

  task automatic m_step(input in_t x);
    bit h, r, g;
    int nv[4];
    h = m_haz(x);
    r = m_redir(x);
    g = m_go(x);
    if (x.rst) begin
      for (int i = 0; i < 4; i++) mvalid[i] = 0;
      mhalt = 0; mack = 0; mcnt = 0;
    end else if (x.mw) begin
      mack = 0;
      if (x.clr) mcnt = 0;
    end else begin
      nv[3] = mvalid[2];
      nv[2] = mvalid[1];
      if (r || mhalt)  begin nv[1] = 0; nv[0] = 0; end
      else if (h)      begin nv[1] = 0; nv[0] = mvalid[0]; end
      else if (g)      begin nv[1] = 1; nv[0] = 0; end
      else             begin nv[1] = mvalid[0]; nv[0] = int'(x.fetch); end
      if (x.clr) mcnt = 0;
      else if (h && !r && !mhalt) mcnt = (mcnt + 1 > CMAX) ? CMAX : mcnt + 1;
      mack = mhalt && x.intr;
      if (mhalt) mhalt = !x.intr;
      else       mhalt = g;
      for (int i = 0; i < 4; i++) mvalid[i] = nv[i];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x);
    rst = x.rst; fetch = x.fetch; sa = x.sa; ca = x.ca; sb = x.sb; cb = x.cb;
    hlt = x.hlt; ed = x.ed; ec = x.ec; ece = x.ece; ecm = x.ecm;
    md = x.md; mc = x.mc; mcm = x.mcm; br = x.br; mw = x.mw;
    intr = x.intr; clr = x.clr;
  endtask

  // Drive, then check every output against the model at the falling edge
  task automatic cyc(input in_t x);
    drive(x);
    @(negedge clk);
    chk("d_valid", dv, mvalid[0]);
    chk("e_valid", ev, mvalid[1]);
    chk("m_valid", mvld, mvalid[2]);
    chk("w_valid", wv, mvalid[3]);
    chk("halted", halted, mhalt);
    chk("int_ack", ack, mack);
    chk("stall_cnt", cnt, mcnt);
    chk("f_stall", fs, m_fs(x));
    chk("d_stall", ds, m_ds(x));
    chk("pc_sel", pcs, m_redir(x));
  endtask

  task automatic adv(input in_t x);
    m_step(x);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input in_t x);
    cyc(x);
    adv(x);
  endtask

  task automatic do_reset();
    in_t x;
    x = idle();
    x.rst = 1;
    drive(x);
    @(negedge clk);
    adv(x);
  endtask

  task automatic fill(input int n);
    in_t x;
    x = idle();
    x.fetch = 1;
    for (int i = 0; i < n; i++) step(x);
  endtask

  task automatic add(input bit f, input bit [2:0] a, input bit a_cs,
                     input bit [2:0] b, input bit b_cs,
                     input bit [2:0] e_d, input bit e_cs, input bit e_e, input bit e_m,
                     input bit [2:0] m_d, input bit m_cs, input bit m_m,
                     input bit b_t, input bit w,
                     input bit [3:0] v, input bit st, input bit pc, input int c);
    vec_t r;
    r.in = idle();
    r.in.fetch = f; r.in.sa = a; r.in.ca = a_cs; r.in.sb = b; r.in.cb = b_cs;
    r.in.ed = e_d; r.in.ec = e_cs; r.in.ece = e_e; r.in.ecm = e_m;
    r.in.md = m_d; r.in.mc = m_cs; r.in.mcm = m_m; r.in.br = b_t; r.in.mw = w;
    r.v = v; r.st = st; r.pc = pc; r.cnt = c;
    tbl.push_back(r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t x;
    bit [3:0] got;
    bit done;

    drive(idle());
    @(posedge clk);
    #1;

    // fill: f  sa c sb c  ed c e m  md c m  br mw  DEMW    st pc cnt
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b0000, 0,0,0);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1000, 0,0,0);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1100, 0,0,0);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1110, 0,0,0);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1111, 0,0,0);
    // load r3 in E, then in M: two stall cycles
    add(1, 3,1, 0,0, 3,1,0,1, 0,0,0, 0,0, 4'b1111, 1,0,0);
    add(1, 3,1, 0,0, 0,0,0,0, 3,1,1, 0,0, 4'b1011, 1,0,1);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1001, 0,0,2);
    // ALU r3 in E: one stall, then M-stage ALU result does not stall
    add(1, 3,1, 0,0, 3,1,1,0, 0,0,0, 0,0, 4'b1100, 1,0,2);
    add(1, 3,1, 0,0, 0,0,0,0, 3,1,0, 0,0, 4'b1010, 0,0,3);
    // dest r2 vs src r3: no stall; source B hazard stalls
    add(1, 3,1, 0,0, 2,1,0,1, 0,0,0, 0,0, 4'b1101, 0,0,3);
    add(1, 0,0, 5,1, 5,1,1,0, 0,0,0, 0,0, 4'b1110, 1,0,3);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1011, 0,0,4);
    // taken branch with concurrent hazard: redirect wins, D and E squashed
    add(1, 3,1, 0,0, 3,1,1,0, 0,0,0, 1,0, 4'b1101, 0,1,4);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b0010, 0,0,4);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1001, 0,0,4);
    // memory wait 3 cycles with pending hazard and branch: all frozen
    add(1, 3,1, 0,0, 3,1,0,1, 0,0,0, 1,1, 4'b1100, 1,0,4);
    add(1, 3,1, 0,0, 3,1,0,1, 0,0,0, 1,1, 4'b1100, 1,0,4);
    add(1, 3,1, 0,0, 3,1,0,1, 0,0,0, 1,1, 4'b1100, 1,0,4);
    add(1, 3,1, 0,0, 3,1,0,1, 0,0,0, 0,0, 4'b1100, 1,0,4);
    add(1, 0,0, 0,0, 0,0,0,0, 0,0,0, 0,0, 4'b1010, 0,0,5);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      @(negedge clk);
      got = {dv, ev, mvld, wv};
      chk($sformatf("vec%0d_valid", i), got, tbl[i].v);
      chk($sformatf("vec%0d_fstall", i), fs, tbl[i].st);
      chk($sformatf("vec%0d_dstall", i), ds, tbl[i].st);
      chk($sformatf("vec%0d_pcsel", i), pcs, tbl[i].pc);
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
      adv(tbl[i].in);
    end

    // HLT, drain, interrupt wake-up
    do_reset();
    fill(4);
    x = idle(); x.fetch = 1; x.hlt = 1;
    cyc(x); chk("hlt_not_yet_halted", halted, 0); adv(x);
    x.hlt = 0;
    cyc(x); chk("halted_after_hlt", halted, 1); chk("halt_d_zero", dv, 0);
    chk("halt_hlt_in_e", ev, 1); adv(x);
    step(x);
    step(x);
    cyc(x); chk("halt_drained", wv, 0); chk("halt_d_still_zero", dv, 0); adv(x);
    x.intr = 1;
    cyc(x); chk("ack_before_exit", ack, 0); adv(x);
    x.intr = 0;
    cyc(x); chk("ack_pulse", ack, 1); chk("run_after_int", halted, 0);
    chk("fetch_unstalled", fs, 0); adv(x);
    x.intr = 1;
    cyc(x); chk("ack_single", ack, 0); chk("fetch_resumed", dv, 1); adv(x);
    x.intr = 0;
    cyc(x); chk("int_in_run_ignored", ack, 0); adv(x);

    // reset while halted
    do_reset();
    fill(2);
    x = idle(); x.fetch = 1; x.hlt = 1;
    step(x);
    x.hlt = 0;
    step(x);
    cyc(x); chk("in_halt_before_rst", halted, 1); adv(x);
    x.rst = 1; x.intr = 1;
    step(x);
    x = idle();
    cyc(x);
    got = {dv, ev, mvld, wv};
    chk("rst_halt_state", halted, 0); chk("rst_valids", got, 0);
    chk("rst_ack", ack, 0); chk("rst_cnt", cnt, 0);
    adv(x);

    // counter saturation under a persistent load-use pattern
    do_reset();
    fill(4);
    x = idle(); x.fetch = 1; x.sa = 1; x.ca = 1;
    x.ed = 1; x.ec = 1; x.ecm = 1; x.md = 1; x.mc = 1; x.mcm = 1;
    for (int i = 0; i < 40; i++) step(x);
    cyc(x); chk("cnt_saturated", cnt, CMAX); adv(x);
    done = 0;
    for (int i = 0; i < 4 && !done; i++) begin
      if (m_haz(x)) begin
        x.clr = 1;
        cyc(x); chk("clr_with_stall_fstall", fs, 1); adv(x);
        x.clr = 0;
        cyc(x); chk("clr_beats_inc", cnt, 0); adv(x);
        done = 1;
      end else begin
        step(x);
      end
    end
    chk("clr_hazard_found", done, 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      x = idle();
      x.rst   = ($urandom_range(0, 149) == 0);
      x.fetch = ($urandom_range(0, 3) != 0);
      x.sa = 3'($urandom_range(0, 3)); x.ca = $urandom_range(0, 1);
      x.sb = 3'($urandom_range(0, 3)); x.cb = $urandom_range(0, 1);
      x.ed = 3'($urandom_range(0, 3)); x.ec = $urandom_range(0, 1);
      x.ece = $urandom_range(0, 1); x.ecm = $urandom_range(0, 1);
      x.md = 3'($urandom_range(0, 3)); x.mc = $urandom_range(0, 1);
      x.mcm = $urandom_range(0, 1);
      x.br   = !mhalt && ($urandom_range(0, 5) == 0);
      x.mw   = ($urandom_range(0, 7) == 0);
      x.hlt  = ($urandom_range(0, 9) == 0);
      x.intr = ($urandom_range(0, 5) == 0);
      x.clr  = !x.mw && ($urandom_range(0, 29) == 0);
      step(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
Name: cpu_pipe_ctrl

Overview:
Pipeline sequencing controller for the 8-bit five-stage CPU (F/D/E/M/W). Owns the per-stage valid bits consumed by the operand-forwarding network. Generates fetch/decode stall, squash and PC-redirect controls from load-use hazards, taken branches, memory wait and HLT. Keeps a saturating hazard-stall counter for performance debug.

Parameters:
CNT_W, 16, width of hazard-stall counter STALL_CNT_O

Ports:
CLK_I  input  1  clock, all state on rising edge
RST_I  input  1  synchronous active-high reset
FETCH_VALID_I  input  1  fetch stage presents an instruction this cycle
D_SRC_A_I  input  3  D-stage source register A index
D_SRC_A_CS_I  input  1  D-stage instruction reads source A
D_SRC_B_I  input  3  D-stage source register B index
D_SRC_B_CS_I  input  1  D-stage instruction reads source B
D_HLT_I  input  1  D-stage instruction is HLT
E_DSTR_I  input  3  E-stage destination register
E_DSTR_CS_I  input  1  E-stage instruction writes a register
E_DSTR_CS_E_I  input  1  E-stage result comes from ALU (ready end of E, usable from M)
E_DSTR_CS_M_I  input  1  E-stage result comes from memory (usable from W)
M_DSTR_I  input  3  M-stage destination register
M_DSTR_CS_I  input  1  M-stage instruction writes a register
M_DSTR_CS_M_I  input  1  M-stage result comes from memory
BR_TAKEN_I  input  1  E-stage branch/jump/call/ret resolved taken
MEM_WAIT_I  input  1  data/instruction memory not ready; freeze whole pipe
INT_I  input  1  interrupt request (wakes HALT)
CNT_CLR_I  input  1  clear stall counter
D_VALID_O  output  1  D stage holds live instruction (registered)
E_VALID_O  output  1  E stage valid (registered)
M_VALID_O  output  1  M stage valid (registered)
W_VALID_O  output  1  W stage valid (registered)
F_STALL_O  output  1  hold PC/fetch register (combinational)
D_STALL_O  output  1  hold D pipeline register (combinational)
PC_SEL_O  output  1  load PC from branch target (combinational)
HALTED_O  output  1  controller in HALT state (registered)
INT_ACK_O  output  1  one-cycle pulse on HALT exit (registered)
STALL_CNT_O  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (RST_I=1 at edge): all valid bits 0, state RUN, HALTED_O=0, INT_ACK_O=0, STALL_CNT_O=0. Reset wins over every other input, including mid-freeze or in HALT.
- Hazard per source X in {A,B}: hazX = D_VALID_O & D_SRC_X_CS_I & [ (E_VALID_O & E_DSTR_CS_I & E_DSTR_I==D_SRC_X_I & (E_DSTR_CS_E_I|E_DSTR_CS_M_I)) | (M_VALID_O & M_DSTR_CS_I & M_DSTR_I==D_SRC_X_I & M_DSTR_CS_M_I) ]. haz = hazA|hazB. Compare is full 3-bit equality.
- redir = E_VALID_O & BR_TAKEN_I & ~MEM_WAIT_I; PC_SEL_O = redir.
- Priority per cycle: RST_I > MEM_WAIT_I (freeze) > redir > haz > normal advance.
- Freeze: all valid bits hold, F_STALL_O=D_STALL_O=1, PC_SEL_O=0, counter holds, state holds.
- Advance (no freeze): W<=M, M<=E valid bits always shift.
  redir: E<=0, D<=0 (squash D and fetched instr); stalls 0.
  haz (no redir): E<=0 (bubble), D holds; F_STALL_O=D_STALL_O=1; counter +1 saturating at all-ones.
  normal RUN: E<=D_VALID_O, D<=FETCH_VALID_I.
- HLT: in RUN, if D_VALID_O & D_HLT_I & ~haz & ~redir & ~freeze: HLT advances to E, D<=0, state->HALT next cycle.
- HALT: D<=0, F_STALL_O=1, D_STALL_O=1; older instrs keep draining E->M->W. HALTED_O=1. INT_I=1 (no freeze) -> RUN next cycle, INT_ACK_O=1 for exactly that one cycle; fetch resumes the following cycle. INT_I in RUN ignored here.
- CNT_CLR_I clears counter next edge; has priority over same-cycle increment.
- Latency: valid bits update 1 cycle after edge; stall/redirect outputs same-cycle combinational.

Test Plan:
- Reset then FETCH_VALID_I=1 continuously, no hazards -> D,E,M,W valid rise on cycles 1,2,3,4; stalls never assert.
- D reads r3 (SRC_A, CS=1) while E writes r3 with CS_M=1 -> 2 stall cycles (E then M), two bubbles into E, STALL_CNT_O=2; E writes r3 with CS_E only -> 1 stall; dest r2 vs src r3 -> 0 stalls.
- BR_TAKEN_I with E valid and simultaneous hazard -> PC_SEL_O=1, D and next E squashed, no stall, counter unchanged.
- MEM_WAIT_I high 3 cycles mid-stream with pending hazard -> all valid bits frozen, counter frozen, resume exactly where left.
- HLT in D -> HALTED_O=1 after 1 cycle, D_VALID_O stays 0, W drains; INT_I pulse -> INT_ACK_O single 1-cycle pulse, HALTED_O=0, fetch resumes next cycle.
- CNT_W=4, force 20 hazard cycles -> STALL_CNT_O saturates at 15; CNT_CLR_I with concurrent stall -> 0; RST_I asserted in HALT -> RUN, all zero.
